cdb_arbiter: RTL and testbench

//  Producer end of the common data bus (CDB) that the reservation stations snoop.

---
 rtl/cdb_pkg.sv | 25 ++
 rtl/cdb_arbiter_if.sv | 26 ++
 rtl/cdb_rr_arbiter.sv | 29 ++
 rtl/cdb_arbiter.sv | 114 +++++++++++
 tb/tb_cdb_arbiter.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/cdb_pkg.sv
// Shared CDB types: broadcast entry, reserved null tag and one-hot decode helper.
package cdb_pkg;

    localparam int unsigned CDB_XLEN      = 32;
    localparam int unsigned CDB_TAG_WIDTH = 32;
    localparam int unsigned CDB_MAX_FU    = 32;

    localparam logic [CDB_TAG_WIDTH-1:0] NULL_TAG = '0;

    typedef struct packed {
        logic [CDB_TAG_WIDTH-1:0] tag;
        logic [CDB_XLEN-1:0]      data;
    } cdb_entry_t;

    // OR-reduction decode; only valid for a one-hot (or zero) input.
    function automatic int unsigned onehot_to_idx(input logic [CDB_MAX_FU-1:0] onehot);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < CDB_MAX_FU; i++) begin
            if (onehot[i]) idx = idx | i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Functional-unit result ports and CDB broadcast outputs of the CDB arbiter.
interface cdb_arbiter_if #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned TAG_WIDTH = 32,
    parameter int unsigned NUM_FU    = 4
);
    logic                        flush;
    logic [NUM_FU-1:0]           fu_valid;
    logic [NUM_FU*TAG_WIDTH-1:0] fu_tag;
    logic [NUM_FU*XLEN-1:0]      fu_data;
    logic [NUM_FU-1:0]           fu_ready;
    logic                        cdb_enable;
    logic [TAG_WIDTH-1:0]        cdb_tag;
    logic [XLEN-1:0]             cdb_data;
    logic                        tag0_err;

    modport master (
        output flush, fu_valid, fu_tag, fu_data,
        input  fu_ready, cdb_enable, cdb_tag, cdb_data, tag0_err
    );

    modport slave (
        input  flush, fu_valid, fu_tag, fu_data,
        output fu_ready, cdb_enable, cdb_tag, cdb_data, tag0_err
    );
endinterface

// File: rtl/cdb_rr_arbiter.sv
// One-hot grant search over req starting at ptr; with ptr tied to 0 it is a
// lowest-index-wins priority encoder.
module cdb_rr_arbiter #(
    parameter int unsigned NUM_FU = 4,
    localparam int unsigned PtrW  = $clog2(NUM_FU)
) (
    input  logic [NUM_FU-1:0] req,
    input  logic [PtrW-1:0]   ptr,
    output logic [NUM_FU-1:0] grant
);
    always_comb begin
        logic [PtrW:0]   sum;
        logic [PtrW-1:0] idx;
        logic            found;
        grant = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int unsigned k = 0; k < NUM_FU; k++) begin
            sum = {1'b0, ptr} + (PtrW+1)'(k);
            if (sum >= (PtrW+1)'(NUM_FU)) sum = sum - (PtrW+1)'(NUM_FU);
            idx = sum[PtrW-1:0];
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/cdb_arbiter.sv
// CDB producer: per-FU one-entry result buffers, one registered broadcast per cycle.
// Define CDB_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index).
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int unsigned XLEN      = CDB_XLEN,
    parameter int unsigned TAG_WIDTH = CDB_TAG_WIDTH,
    parameter int unsigned NUM_FU    = 4
) (
    input  logic          clk,
    input  logic          reset,
    cdb_arbiter_if.slave  bus
);
    localparam int unsigned PtrW = $clog2(NUM_FU);

    cdb_entry_t           entry_q [NUM_FU];
    cdb_entry_t           entry_d [NUM_FU];
    logic [NUM_FU-1:0]    valid_q, valid_d;
    logic [NUM_FU-1:0]    grant, accept;
    logic [PtrW-1:0]      gidx, rr_ptr;
    logic                 en_q, en_d;
    logic [TAG_WIDTH-1:0] tag_q, tag_d;
    logic [XLEN-1:0]      data_q, data_d;
    logic                 err_q, err_d;

`ifdef CDB_RR_EN
    logic [PtrW-1:0] rr_q, rr_d;
    assign rr_ptr = rr_q;
`else
    assign rr_ptr = '0;
`endif

    cdb_rr_arbiter #(
        .NUM_FU (NUM_FU)
    ) u_arb (
        .req   (valid_q),
        .ptr   (rr_ptr),
        .grant (grant)
    );

    assign gidx   = PtrW'(onehot_to_idx(CDB_MAX_FU'(grant)));
    // A granted slot drains this edge, so it can take a new result at the same time.
    assign bus.fu_ready = (reset && !bus.flush) ? (~valid_q | grant) : '0;
    assign accept       = bus.fu_valid & bus.fu_ready;

    always_comb begin
        valid_d = valid_q;
        entry_d = entry_q;
        en_d    = 1'b0;
        tag_d   = tag_q;
        data_d  = data_q;
        err_d   = err_q;
`ifdef CDB_RR_EN
        rr_d    = rr_q;
`endif
        if (bus.flush) begin
            valid_d = '0;
        end else begin
            if (|grant) begin
                en_d          = 1'b1;
                tag_d         = entry_q[gidx].tag;
                data_d        = entry_q[gidx].data;
                valid_d[gidx] = 1'b0;
`ifdef CDB_RR_EN
                rr_d = (gidx == PtrW'(NUM_FU - 1)) ? '0 : gidx + 1'b1;
`endif
            end
            for (int unsigned i = 0; i < NUM_FU; i++) begin
                if (accept[i]) begin
                    // Tag 0 means "operand ready"; swallow it rather than broadcast it.
                    if (bus.fu_tag[i*TAG_WIDTH +: TAG_WIDTH] == NULL_TAG) begin
                        err_d = 1'b1;
                    end else begin
                        valid_d[i]      = 1'b1;
                        entry_d[i].tag  = bus.fu_tag[i*TAG_WIDTH +: TAG_WIDTH];
                        entry_d[i].data = bus.fu_data[i*XLEN +: XLEN];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q <= '0;
            en_q    <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
`ifdef CDB_RR_EN
            rr_q    <= '0;
`endif
        end else begin
            valid_q <= valid_d;
            en_q    <= en_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
            err_q   <= err_d;
`ifdef CDB_RR_EN
            rr_q    <= rr_d;
`endif
        end
    end

    // Payload is qualified by valid_q, so it needs no reset.
    always_ff @(posedge clk) begin
        entry_q <= entry_d;
    end

    assign bus.cdb_enable = en_q;
    assign bus.cdb_tag    = tag_q;
    assign bus.cdb_data   = data_q;
    assign bus.tag0_err   = err_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed and random stimulus for cdb_arbiter against a per-port slot model.
module tb_cdb_arbiter;
    localparam int N = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    cdb_arbiter_if #(.XLEN(32), .TAG_WIDTH(32), .NUM_FU(N)) bus ();

    cdb_arbiter #(
        .XLEN      (32),
        .TAG_WIDTH (32),
        .NUM_FU    (N)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: one slot per port plus the visible CDB registers.
    bit          m_valid [N];
    logic [31:0] m_tag   [N];
    logic [31:0] m_data  [N];
    int          m_rr;
    bit          m_en;
    logic [31:0] m_ctag, m_cdata;
    bit          m_err;

    logic [31:0]  in_tag  [N];
    logic [31:0]  in_data [N];
    logic [N-1:0] last_ready;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic step(input logic rst, input logic fl, input logic [N-1:0] v);
        int g;
        logic [N-1:0] er;
        @(negedge clk);
        reset    = rst;
        bus.flush    = fl;
        bus.fu_valid = v;
        for (int i = 0; i < N; i++) begin
            bus.fu_tag[i*32 +: 32]  = in_tag[i];
            bus.fu_data[i*32 +: 32] = in_data[i];
        end
        g = -1;
        for (int k = 0; k < N; k++) begin
            int p;
`ifdef CDB_RR_EN
            p = (m_rr + k) % N;
`else
            p = k;
`endif
            if (g < 0 && m_valid[p]) g = p;
        end
        for (int i = 0; i < N; i++) er[i] = rst && !fl && (!m_valid[i] || g == i);
        #1;
        last_ready = bus.fu_ready;
        check("fu_ready", bus.fu_ready, er);

        if (!rst) begin
            for (int i = 0; i < N; i++) m_valid[i] = 0;
            m_rr = 0; m_en = 0; m_ctag = 0; m_cdata = 0; m_err = 0;
        end else if (fl) begin
            for (int i = 0; i < N; i++) m_valid[i] = 0;
            m_en = 0;
        end else begin
            m_en = (g >= 0);
            if (g >= 0) begin
                m_ctag = m_tag[g]; m_cdata = m_data[g];
                m_valid[g] = 0;
                m_rr = (g + 1) % N;
            end
            for (int i = 0; i < N; i++) begin
                if (v[i] && er[i]) begin
                    if (in_tag[i] == 0) m_err = 1;
                    else begin
                        m_valid[i] = 1; m_tag[i] = in_tag[i]; m_data[i] = in_data[i];
                    end
                end
            end
        end

        @(posedge clk);
        #1;
        check("cdb_enable", bus.cdb_enable, m_en);
        check("cdb_tag", bus.cdb_tag, m_ctag);
        check("cdb_data", bus.cdb_data, m_cdata);
        check("tag0_err", bus.tag0_err, m_err);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0);
    endtask

    task automatic set_port(input int p, input logic [31:0] t, input logic [31:0] d);
        in_tag[p]  = t;
        in_data[p] = d;
    endtask

    initial begin
        int seen9;
        bus.flush = 1'b0; bus.fu_valid = '0; bus.fu_tag = '0; bus.fu_data = '0;
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_data[i] = 0; in_tag[i] = 0; in_data[i] = 0;
        end
        m_rr = 0; m_en = 0; m_ctag = 0; m_cdata = 0; m_err = 0;

        // Reset state
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        check("rst_ready", last_ready, 4'b0000);
        check("rst_enable", bus.cdb_enable, 1'b0);

        // 1: single result, two-edge latency, one-cycle pulse
        set_port(1, 32'd5, 32'hDEAD);
        step(1'b1, 1'b0, 4'b0010);
        check("t1_not_yet", bus.cdb_enable, 1'b0);
        idle(1);
        check("t1_en", bus.cdb_enable, 1'b1);
        check("t1_tag", bus.cdb_tag, 32'd5);
        check("t1_data", bus.cdb_data, 32'hDEAD);
        idle(1);
        check("t1_pulse", bus.cdb_enable, 1'b0);
        check("t1_tag_hold", bus.cdb_tag, 32'd5);

        // 2: four-way contention from rr_ptr = 0
        step(1'b0, 1'b0, '0);
        for (int i = 0; i < N; i++) set_port(i, 32'(i + 1), 32'(100 + i));
        step(1'b1, 1'b0, '1);
        for (int i = 0; i < N; i++) begin
            idle(1);
            check("t2_order", bus.cdb_tag, 32'(i + 1));
        end
        idle(1);
        check("t2_drained", bus.cdb_enable, 1'b0);

        // 3: fairness with FU0 streaming and FU2 offering tag 9 once
        step(1'b0, 1'b0, '0);
        seen9 = -1;
        set_port(2, 32'd9, 32'h99);
        for (int s = 1; s <= 8; s++) begin
            set_port(0, 32'(200 + s), 32'(s));
            step(1'b1, 1'b0, (s == 1) ? 4'b0101 : 4'b0001);
            if (seen9 < 0 && bus.cdb_enable && bus.cdb_tag == 32'd9) seen9 = s;
        end
`ifdef CDB_RR_EN
        check("t3_fair", 64'(seen9), 64'(3));
`else
        check("t3_starved", 64'(seen9), 64'(-1));
`endif
        idle(3);

        // 4: tag-0 is consumed, never broadcast, sticky error
        step(1'b0, 1'b0, '0);
        set_port(3, 32'd0, 32'd7);
        step(1'b1, 1'b0, 4'b1000);
        check("t4_accepted", last_ready[3], 1'b1);
        check("t4_err", bus.tag0_err, 1'b1);
        idle(2);
        check("t4_no_bcast", bus.cdb_enable, 1'b0);
        check("t4_sticky", bus.tag0_err, 1'b1);

        // 5: flush with three full buffers
        for (int i = 0; i < 3; i++) set_port(i, 32'(11 + i), 32'(i));
        step(1'b1, 1'b0, 4'b0111);
        step(1'b1, 1'b1, '0);
        check("t5_ready_low", last_ready, 4'b0000);
        check("t5_en_low", bus.cdb_enable, 1'b0);
        check("t5_err_kept", bus.tag0_err, 1'b1);
        idle(1);
        check("t5_all_ready", last_ready, 4'b1111);
        check("t5_no_stale", bus.cdb_enable, 1'b0);

        // 6: reset while a broadcast is pending
        set_port(1, 32'd21, 32'h55);
        step(1'b1, 1'b0, 4'b0010);
        step(1'b0, 1'b0, '0);
        check("t6_ready", last_ready, 4'b0000);
        check("t6_en", bus.cdb_enable, 1'b0);
        check("t6_tag", bus.cdb_tag, 32'd0);
        check("t6_err", bus.tag0_err, 1'b0);
        idle(2);

        // Random traffic
        for (int s = 0; s < 400; s++) begin
            for (int i = 0; i < N; i++)
                set_port(i, ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom, $urandom);
            step(($urandom_range(0, 99) != 0), ($urandom_range(0, 19) == 0),
                 N'($urandom_range(0, 15)));
        end
        idle(N + 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
